// File: rtl/dram_req_sched.sv
// DRAM request scheduler: buffers requests, decodes DDR4 address fields, tracks open rows per bank
// and issues one command at a time. Optional DRAM_REQ_SCHED_STATS_EN adds policy/drop counters.
module dram_req_sched #(
  parameter int DEPTH = 16,
  parameter int AW    = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [1:0]    issue_op,
  output logic          issue_rd_wr,
  output logic [1:0]    issue_policy,
  output logic [1:0]    issue_bank_group,
  output logic [1:0]    issue_bank,
  output logic [14:0]   issue_row,
  output logic [10:0]   issue_column,
  output logic          issue_diff_bg,
  output logic          issue_diff_b,
  input  logic          cmd_done,
`ifdef DRAM_REQ_SCHED_STATS_EN
  output logic [31:0]   stat_hit,
  output logic [31:0]   stat_miss,
  output logic [31:0]   stat_empty,
  output logic [15:0]   stat_drop,
`endif
  output logic          busy
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, WAIT_DONE} state_t;
  state_t state, state_nxt;

  // byte offset bits never reach the DRAM fields, so they are not stored
  logic [1:0]    fifo_op   [DEPTH];
  logic [AW-4:0] fifo_addr [DEPTH];
  logic [PW:0]   wp, rp;
  logic          empty, full, accept, push, drop, pop, hs;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^req_addr[2:0];
  assign empty  = (wp == rp);
  assign full   = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign accept = req_valid && !full;
  assign push   = accept && (req_op != 2'd3);
  assign drop   = accept && (req_op == 2'd3);
  assign pop    = (state == IDLE) && !empty;
  assign hs     = (state == ISSUE) && issue_ready;

  assign req_ready    = !full;
  assign busy         = !empty || (state != IDLE);
  assign issue_valid  = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wp[PW-1:0]]   <= req_op;
      fifo_addr[wp[PW-1:0]] <= req_addr[AW-1:3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty) state_nxt = DECODE;
      DECODE:    state_nxt = ISSUE;
      ISSUE:     if (issue_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (cmd_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // holding register; addresses are stored from bit 3 up
  logic [1:0]    hold_op;
  logic [AW-4:0] hold_addr;
  logic [14:0]   d_row;
  logic [10:0]   d_col;
  logic [1:0]    d_bank, d_bg;
  logic [3:0]    bidx;
  logic [1:0]    d_pol;
  logic          d_diff_bg, d_diff_b;

  logic [14:0]   open_row [16];
  logic [15:0]   open_vld;
  logic [1:0]    last_bg, last_b;
  logic          last_vld;
  logic [1:0]    pol_q;

  assign d_row  = hold_addr[29:15];
  assign d_col  = {hold_addr[14:7], hold_addr[2:0]};
  assign d_bank = hold_addr[6:5];
  assign d_bg   = hold_addr[4:3];
  assign bidx   = {d_bg, d_bank};

  always_comb begin
    d_pol = 2'd3;
    if (open_vld[bidx]) d_pol = (open_row[bidx] == d_row) ? 2'd1 : 2'd2;
  end

  assign d_diff_bg = last_vld && (last_bg != d_bg);
  assign d_diff_b  = last_vld && (last_bg == d_bg) && (last_b != d_bank);

  // policy reads as 0 whenever no command is in flight
  assign issue_policy = (state == ISSUE || state == WAIT_DONE) ? pol_q : 2'd0;

  always_ff @(posedge clk) begin
    if (hs) open_row[{issue_bank_group, issue_bank}] <= issue_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_op          <= '0;
      hold_addr        <= '0;
      issue_op         <= '0;
      issue_rd_wr      <= 1'b0;
      pol_q            <= '0;
      issue_bank_group <= '0;
      issue_bank       <= '0;
      issue_row        <= '0;
      issue_column     <= '0;
      issue_diff_bg    <= 1'b0;
      issue_diff_b     <= 1'b0;
      open_vld         <= '0;
      last_bg          <= '0;
      last_b           <= '0;
      last_vld         <= 1'b0;
    end else begin
      if (pop) begin
        hold_op   <= fifo_op[rp[PW-1:0]];
        hold_addr <= fifo_addr[rp[PW-1:0]];
      end
      if (state == DECODE) begin
        issue_op         <= hold_op;
        issue_rd_wr      <= (hold_op == 2'd1);
        pol_q            <= d_pol;
        issue_bank_group <= d_bg;
        issue_bank       <= d_bank;
        issue_row        <= d_row;
        issue_column     <= d_col;
        issue_diff_bg    <= d_diff_bg;
        issue_diff_b     <= d_diff_b;
      end
      if (hs) begin
        open_vld[{issue_bank_group, issue_bank}] <= 1'b1;
        last_bg  <= issue_bank_group;
        last_b   <= issue_bank;
        last_vld <= 1'b1;
      end
    end
  end

`ifdef DRAM_REQ_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hit   <= '0;
      stat_miss  <= '0;
      stat_empty <= '0;
      stat_drop  <= '0;
    end else begin
      if (hs && pol_q == 2'd1 && stat_hit   != '1) stat_hit   <= stat_hit + 1'b1;
      if (hs && pol_q == 2'd2 && stat_miss  != '1) stat_miss  <= stat_miss + 1'b1;
      if (hs && pol_q == 2'd3 && stat_empty != '1) stat_empty <= stat_empty + 1'b1;
      if (drop && stat_drop != '1)                 stat_drop  <= stat_drop + 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
